// File: rtl/lf_pkg.sv
// ---------------------------------------------------------------------------
// lf_pkg
// Shared types and encodings for the line-follower navigation controller.
//   nav_state_t  : navigation FSM states
//   line_class_t : line-position class derived from one sensor sample
//   MD_*         : motor_dir encodings {in4,in3,in2,in1}
// ---------------------------------------------------------------------------
package lf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_NODE_ACT,
        ST_GAP_SEARCH,
        ST_DONE
    } nav_state_t;

    typedef enum logic [2:0] {
        CL_CENTER,
        CL_LEFT,
        CL_RIGHT,
        CL_NODE,
        CL_GAP
    } line_class_t;

    localparam logic [3:0] MD_BRAKE = 4'b0000;
    localparam logic [3:0] MD_FWD   = 4'b0101;
    localparam logic [3:0] MD_RIGHT = 4'b0110;
    localparam logic [3:0] MD_LEFT  = 4'b1001;

endpackage

// File: rtl/lf_classify.sv
// ---------------------------------------------------------------------------
// lf_classify
// Quantises each sensor channel against a threshold (black when
// sample >= threshold) and classifies the resulting bit vector. The class of
// the current sample is available combinationally so the controller can act
// on it in the same cycle; the last valid class is also registered so the
// controller can keep steering on it while no new sample arrives.
// Ports:
//   i_clk, i_rst        : clock, async active-high reset
//   i_sens_data         : packed samples, channel 0 (leftmost) in the LSBs
//   i_sens_valid        : qualifies i_sens_data
//   i_thresh            : black/white threshold
//   o_class_now         : class of i_sens_data (meaningful when valid)
//   o_class_last        : class of the most recent valid sample
// ---------------------------------------------------------------------------
import lf_pkg::*;

module lf_classify #(
    parameter int N_SENS = 3,
    parameter int ADC_W  = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_SENS*ADC_W-1:0] i_sens_data,
    input  logic                    i_sens_valid,
    input  logic [ADC_W-1:0]        i_thresh,
    output line_class_t             o_class_now,
    output line_class_t             o_class_last
);

    localparam int HALF = N_SENS / 2;

    logic [N_SENS-1:0] w_bits;
    logic              w_left_any;
    logic              w_right_any;
    line_class_t       w_class;
    line_class_t       r_class_last;

    for (genvar g = 0; g < N_SENS; g++) begin : g_quant
        assign w_bits[g] = (i_sens_data[g*ADC_W +: ADC_W] >= i_thresh);
    end

    // The middle channel (index HALF) never decides left versus right.
    always_comb begin
        w_left_any  = 1'b0;
        w_right_any = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            w_left_any = w_left_any | w_bits[i];
        end
        for (int i = HALF + 1; i < N_SENS; i++) begin
            w_right_any = w_right_any | w_bits[i];
        end
    end

    always_comb begin
        w_class = CL_CENTER;
        if (&w_bits) begin
            w_class = CL_NODE;
        end else if (~|w_bits) begin
            w_class = CL_GAP;
        end else if (w_left_any && !w_right_any) begin
            w_class = CL_LEFT;
        end else if (w_right_any && !w_left_any) begin
            w_class = CL_RIGHT;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_class_last <= CL_CENTER;
        end else if (i_sens_valid) begin
            r_class_last <= w_class;
        end
    end

    assign o_class_now  = w_class;
    assign o_class_last = r_class_last;

endmodule

// File: rtl/lf_nav_ctrl.sv
// ---------------------------------------------------------------------------
// lf_nav_ctrl
// Line-follower navigation controller. Steers along the line, confirms and
// counts nodes (all-black crossings), executes the per-node plan (right turn
// or straight), searches for the line across gaps and stops after LAPS laps.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_IDLE       | braked, waiting for start
// ST_FOLLOW     | steering on the line class, confirming nodes, spotting gaps
// ST_NODE_ACT   | executing the node plan for TURN_CYC cycles
// ST_GAP_SEARCH | turning toward the flagged side until the line reappears
// ST_DONE       | braked, finish asserted, left only by reset
//
// Ports:
//   i_clk, i_rst   : clock, async active-high reset
//   i_start        : level start request
//   i_sens_data    : packed sensor samples, channel 0 leftmost
//   i_sens_valid   : one-cycle strobe qualifying i_sens_data
//   i_thresh       : black/white threshold
//   i_node_plan    : bit k = 1 turns right at node k, 0 goes straight
//   o_motor_dir    : {in4,in3,in2,in1}
//   o_duty_l/_r    : motor duties
//   o_node_count   : node index counter
//   o_lap_count    : laps completed
//   o_node_pulse   : one-cycle pulse per counted node
//   o_finish       : run complete, sticky until reset
// All outputs are registered; a valid sample shows on the outputs one cycle
// after its strobe.
// ---------------------------------------------------------------------------
import lf_pkg::*;

module lf_nav_ctrl #(
    parameter int N_SENS   = 3,
    parameter int ADC_W    = 12,
    parameter int PWM_W    = 8,
    parameter int NODES    = 8,
    parameter int LAPS     = 2,
    parameter int CONFIRM  = 4,
    parameter int HOLDOFF  = 7812500,
    parameter int TURN_CYC = 1562500,
    parameter int F_DUTY   = 105,
    parameter int S_DUTY   = 95
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [N_SENS*ADC_W-1:0] i_sens_data,
    input  logic                    i_sens_valid,
    input  logic [ADC_W-1:0]        i_thresh,
    input  logic [NODES-1:0]        i_node_plan,
    output logic [3:0]              o_motor_dir,
    output logic [PWM_W-1:0]        o_duty_l,
    output logic [PWM_W-1:0]        o_duty_r,
    output logic [3:0]              o_node_count,
    output logic [1:0]              o_lap_count,
    output logic                    o_node_pulse,
    output logic                    o_finish
);

    localparam int HOLD_W = $clog2(HOLDOFF + 1);
    localparam int TURN_W = $clog2(TURN_CYC + 1);
    localparam int CONF_W = $clog2(CONFIRM + 1);

    localparam logic [PWM_W-1:0] D_CRUISE = PWM_W'(F_DUTY - 15);
    localparam logic [PWM_W-1:0] D_FAST   = PWM_W'(F_DUTY - 10);
    localparam logic [PWM_W-1:0] D_SLOW   = PWM_W'(S_DUTY);
    localparam logic [PWM_W-1:0] D_FULL   = '1;
    localparam logic [PWM_W-1:0] D_ZERO   = '0;

    line_class_t w_class_now;
    line_class_t w_class_last;
    line_class_t w_cls;

    nav_state_t        r_state;
    nav_state_t        w_state_nx;
    logic [3:0]        r_dir, w_dir_nx;
    logic [PWM_W-1:0]  r_duty_l, w_duty_l_nx;
    logic [PWM_W-1:0]  r_duty_r, w_duty_r_nx;
    logic [3:0]        r_node, w_node_nx;
    logic [1:0]        r_lap, w_lap_nx;
    logic              r_pulse, w_pulse_nx;
    logic              r_finish, w_finish_nx;
    logic [TURN_W-1:0] r_turn, w_turn_nx;
    logic              r_search_left, w_search_left_nx;
    logic [HOLD_W-1:0] r_hold;
    logic [CONF_W-1:0] r_conf;

    logic              w_node_hit;
    logic              w_count;
    logic              w_wrap;
    logic [15:0]       w_plan16;
    logic [3:0]        w_st_dir;
    logic [PWM_W-1:0]  w_st_dl;
    logic [PWM_W-1:0]  w_st_dr;

    lf_classify #(
        .N_SENS (N_SENS),
        .ADC_W  (ADC_W)
    ) u_classify (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_sens_data  (i_sens_data),
        .i_sens_valid (i_sens_valid),
        .i_thresh     (i_thresh),
        .o_class_now  (w_class_now),
        .o_class_last (w_class_last)
    );

    // Without a fresh sample the controller keeps acting on the last one.
    assign w_cls    = i_sens_valid ? w_class_now : w_class_last;
    assign w_plan16 = 16'(i_node_plan);

    // The sample that brings the run to CONFIRM counts, unless holdoff is
    // running; a long node saturates the counter so it is never recounted.
    assign w_node_hit = i_sens_valid && (w_class_now == CL_NODE)
                        && (r_conf == CONF_W'(CONFIRM - 1)) && (r_hold == '0);
    assign w_count    = (r_state == ST_FOLLOW) && w_node_hit;
    assign w_wrap     = (r_node == 4'(NODES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_conf <= '0;
        end else if (r_state == ST_IDLE) begin
            r_conf <= '0;
        end else if (i_sens_valid) begin
            if (w_class_now != CL_NODE) begin
                r_conf <= '0;
            end else if (r_conf != CONF_W'(CONFIRM)) begin
                r_conf <= r_conf + CONF_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_count) begin
            r_hold <= HOLD_W'(HOLDOFF);
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
        end
    end

    // Steering from a line class; NODE (not counted) and GAP steer straight.
    always_comb begin
        w_st_dir = MD_FWD;
        w_st_dl  = D_CRUISE;
        w_st_dr  = D_CRUISE;
        case (w_cls)
            CL_LEFT: begin
                w_st_dir = MD_LEFT;
                w_st_dl  = D_SLOW;
                w_st_dr  = D_FAST;
            end
            CL_RIGHT: begin
                w_st_dir = MD_RIGHT;
                w_st_dl  = D_FAST;
                w_st_dr  = D_SLOW;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx       = r_state;
        w_dir_nx         = r_dir;
        w_duty_l_nx      = r_duty_l;
        w_duty_r_nx      = r_duty_r;
        w_node_nx        = r_node;
        w_lap_nx         = r_lap;
        w_pulse_nx       = 1'b0;
        w_finish_nx      = r_finish;
        w_search_left_nx = r_search_left;
        w_turn_nx        = (r_turn != '0) ? (r_turn - TURN_W'(1)) : r_turn;

        case (r_state)
            ST_IDLE: begin
                w_dir_nx    = MD_BRAKE;
                w_duty_l_nx = D_ZERO;
                w_duty_r_nx = D_ZERO;
                if (i_start) begin
                    w_state_nx = ST_FOLLOW;
                end
            end

            ST_FOLLOW: begin
                if (w_count) begin
                    w_pulse_nx = 1'b1;
                    w_node_nx  = w_wrap ? 4'd0 : (r_node + 4'd1);
                    if (w_wrap) begin
                        w_lap_nx = r_lap + 2'd1;
                    end
                    if (w_wrap && ((r_lap + 2'd1) == 2'(LAPS))) begin
                        w_state_nx  = ST_DONE;
                        w_dir_nx    = MD_BRAKE;
                        w_duty_l_nx = D_ZERO;
                        w_duty_r_nx = D_ZERO;
                        w_finish_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_NODE_ACT;
                        w_turn_nx  = TURN_W'(TURN_CYC - 1);
                        if (w_plan16[r_node]) begin
                            w_dir_nx    = MD_RIGHT;
                            w_duty_l_nx = D_FULL;
                            w_duty_r_nx = D_FULL;
                        end else begin
                            w_dir_nx    = MD_FWD;
                            w_duty_l_nx = D_SLOW;
                            w_duty_r_nx = D_SLOW;
                        end
                    end
                end else if (i_sens_valid && (w_class_now == CL_GAP)) begin
                    // The flag names this search's side and flips for the next gap.
                    w_state_nx       = ST_GAP_SEARCH;
                    w_search_left_nx = ~r_search_left;
                    if (r_search_left) begin
                        w_dir_nx    = MD_LEFT;
                        w_duty_l_nx = D_SLOW;
                        w_duty_r_nx = D_FAST;
                    end else begin
                        w_dir_nx    = MD_RIGHT;
                        w_duty_l_nx = D_FAST;
                        w_duty_r_nx = D_SLOW;
                    end
                end else if (i_sens_valid) begin
                    w_dir_nx    = w_st_dir;
                    w_duty_l_nx = w_st_dl;
                    w_duty_r_nx = w_st_dr;
                end
            end

            ST_NODE_ACT: begin
                if (r_turn == '0) begin
                    w_state_nx  = ST_FOLLOW;
                    w_dir_nx    = w_st_dir;
                    w_duty_l_nx = w_st_dl;
                    w_duty_r_nx = w_st_dr;
                end
            end

            ST_GAP_SEARCH: begin
                if (i_sens_valid && (w_class_now != CL_GAP)) begin
                    w_state_nx  = ST_FOLLOW;
                    w_dir_nx    = w_st_dir;
                    w_duty_l_nx = w_st_dl;
                    w_duty_r_nx = w_st_dr;
                end
            end

            ST_DONE: begin
                w_dir_nx    = MD_BRAKE;
                w_duty_l_nx = D_ZERO;
                w_duty_r_nx = D_ZERO;
                w_finish_nx = 1'b1;
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_dir         <= MD_BRAKE;
            r_duty_l      <= '0;
            r_duty_r      <= '0;
            r_node        <= '0;
            r_lap         <= '0;
            r_pulse       <= 1'b0;
            r_finish      <= 1'b0;
            r_turn        <= '0;
            r_search_left <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_dir         <= w_dir_nx;
            r_duty_l      <= w_duty_l_nx;
            r_duty_r      <= w_duty_r_nx;
            r_node        <= w_node_nx;
            r_lap         <= w_lap_nx;
            r_pulse       <= w_pulse_nx;
            r_finish      <= w_finish_nx;
            r_turn        <= w_turn_nx;
            r_search_left <= w_search_left_nx;
        end
    end

    assign o_motor_dir  = r_dir;
    assign o_duty_l     = r_duty_l;
    assign o_duty_r     = r_duty_r;
    assign o_node_count = r_node;
    assign o_lap_count  = r_lap;
    assign o_node_pulse = r_pulse;
    assign o_finish     = r_finish;

endmodule

// File: tb/tb_lf_nav_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lf_nav_ctrl
// Self-checking bench for lf_nav_ctrl. Each driven sample pushes its expected
// outputs to a queue; they are popped and compared one cycle later.
// Fast and slow duties differ from the defaults so that left/right duty
// swaps are visible: cruise 95, fast 100, slow 90, full 255.
// ---------------------------------------------------------------------------
import lf_pkg::*;

module tb_lf_nav_ctrl;

    localparam int N_SENS   = 3;
    localparam int ADC_W    = 12;
    localparam int PWM_W    = 8;
    localparam int NODES    = 4;
    localparam int LAPS     = 2;
    localparam int CONFIRM  = 4;
    localparam int HOLDOFF  = 40;
    localparam int TURN_CYC = 10;
    localparam int F_DUTY   = 110;
    localparam int S_DUTY   = 90;

    localparam int CRU  = F_DUTY - 15;
    localparam int FST  = F_DUTY - 10;
    localparam int SLW  = S_DUTY;
    localparam int FULL = 255;

    localparam logic [ADC_W-1:0] THR = 12'd2048;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [N_SENS*ADC_W-1:0] sens_data;
    logic                    sens_valid;
    logic [ADC_W-1:0]        thresh;
    logic [NODES-1:0]        node_plan;
    logic [3:0]              motor_dir;
    logic [PWM_W-1:0]        duty_l;
    logic [PWM_W-1:0]        duty_r;
    logic [3:0]              node_count;
    logic [1:0]              lap_count;
    logic                    node_pulse;
    logic                    finish;

    lf_nav_ctrl #(
        .N_SENS   (N_SENS),
        .ADC_W    (ADC_W),
        .PWM_W    (PWM_W),
        .NODES    (NODES),
        .LAPS     (LAPS),
        .CONFIRM  (CONFIRM),
        .HOLDOFF  (HOLDOFF),
        .TURN_CYC (TURN_CYC),
        .F_DUTY   (F_DUTY),
        .S_DUTY   (S_DUTY)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_sens_data  (sens_data),
        .i_sens_valid (sens_valid),
        .i_thresh     (thresh),
        .i_node_plan  (node_plan),
        .o_motor_dir  (motor_dir),
        .o_duty_l     (duty_l),
        .o_duty_r     (duty_r),
        .o_node_count (node_count),
        .o_lap_count  (lap_count),
        .o_node_pulse (node_pulse),
        .o_finish     (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dir;
        int         dl;
        int         dr;
        logic       pulse;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_node = 0;
    int   exp_lap  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N_SENS*ADC_W-1:0] mk_data(input logic [N_SENS-1:0] bits,
                                                        input logic [ADC_W-1:0] blk,
                                                        input logic [ADC_W-1:0] wht);
        logic [N_SENS*ADC_W-1:0] d;
        d = '0;
        for (int i = 0; i < N_SENS; i++) begin
            d[i*ADC_W +: ADC_W] = bits[i] ? blk : wht;
        end
        return d;
    endfunction

    // Called at posedge+1; returns at posedge+1 one cycle later.
    task automatic send(input logic [N_SENS-1:0] bits, input logic [3:0] dir,
                        input int dl, input int dr, input logic pulse, input string tag,
                        input logic [ADC_W-1:0] blk = 12'd3000,
                        input logic [ADC_W-1:0] wht = 12'd500);
        exp_t e;
        sens_data  = mk_data(bits, blk, wht);
        sens_valid = 1'b1;
        sb.push_back('{dir, dl, dr, pulse});
        @(posedge clk);
        #1;
        sens_valid = 1'b0;
        e = sb.pop_front();
        chk({tag, "_dir"},   32'(motor_dir),  32'(e.dir));
        chk({tag, "_dl"},    32'(duty_l),     e.dl);
        chk({tag, "_dr"},    32'(duty_r),     e.dr);
        chk({tag, "_pulse"}, 32'(node_pulse), 32'(e.pulse));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles until the motor command changes, bounded.
    task automatic wait_change(output int n);
        logic [3+2*PWM_W:0] v0;
        v0 = {motor_dir, duty_l, duty_r};
        n  = 0;
        while (({motor_dir, duty_l, duty_r} == v0) && (n < 60)) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // kind: 0 straight, 1 right turn, 2 final node (enter DONE)
    task automatic do_node(input int kind, input string tag);
        int n;
        send(3'b010, MD_FWD, CRU, CRU, 1'b0, {tag, "_pre"});
        idle(HOLDOFF + 2);
        for (int i = 0; i < CONFIRM - 1; i++) begin
            send(3'b111, MD_FWD, CRU, CRU, 1'b0, {tag, "_cnf"});
        end
        exp_node = (exp_node + 1) % NODES;
        if (exp_node == 0) exp_lap++;
        if (kind == 0) begin
            send(3'b111, MD_FWD, SLW, SLW, 1'b1, {tag, "_hit"});
        end else if (kind == 1) begin
            send(3'b111, MD_RIGHT, FULL, FULL, 1'b1, {tag, "_hit"});
        end else begin
            send(3'b111, MD_BRAKE, 0, 0, 1'b1, {tag, "_hit"});
        end
        chk({tag, "_node"}, 32'(node_count), exp_node);
        chk({tag, "_lap"},  32'(lap_count),  exp_lap);
        idle(1);
        chk({tag, "_pulse_w"}, 32'(node_pulse), 0);
        if (kind < 2) begin
            wait_change(n);
            chk({tag, "_turn_len"}, n + 1, TURN_CYC);
            chk({tag, "_ret_dir"}, 32'(motor_dir), 32'(MD_FWD));
            chk({tag, "_ret_dl"},  32'(duty_l), CRU);
        end else begin
            chk({tag, "_finish"}, 32'(finish), 1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        sens_valid = 1'b0;
        sens_data  = '0;
        thresh     = THR;
        node_plan  = 4'b0101;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dir",    32'(motor_dir),  0);
        chk("rst_dl",     32'(duty_l),     0);
        chk("rst_dr",     32'(duty_r),     0);
        chk("rst_node",   32'(node_count), 0);
        chk("rst_lap",    32'(lap_count),  0);
        chk("rst_pulse",  32'(node_pulse), 0);
        chk("rst_finish", 32'(finish),     0);
        rst = 1'b0;
        idle(2);

        send(3'b010, MD_BRAKE, 0, 0, 1'b0, "idle_ign");
        pulse_start();
        chk("follow_entry", 32'(motor_dir), 32'(MD_BRAKE));

        // steering
        send(3'b010, MD_FWD, CRU, CRU, 1'b0, "center");
        idle(3);
        chk("hold_dir", 32'(motor_dir), 32'(MD_FWD));
        chk("hold_dl",  32'(duty_l), CRU);
        send(3'b001, MD_LEFT,  SLW, FST, 1'b0, "left1");
        send(3'b011, MD_LEFT,  SLW, FST, 1'b0, "left2");
        send(3'b100, MD_RIGHT, FST, SLW, 1'b0, "right1");
        send(3'b110, MD_RIGHT, FST, SLW, 1'b0, "right2");
        send(3'b101, MD_FWD,   CRU, CRU, 1'b0, "split");
        send(3'b100, MD_RIGHT, FST, SLW, 1'b0, "right3");
        send(3'b010, MD_FWD,   CRU, CRU, 1'b0, "thr_eq", THR, THR - 12'd1);

        // gaps: first searches right, second left
        send(3'b000, MD_RIGHT, FST, SLW, 1'b0, "gap1");
        send(3'b000, MD_RIGHT, FST, SLW, 1'b0, "gap1_hold");
        send(3'b010, MD_FWD,   CRU, CRU, 1'b0, "gap1_back");
        send(3'b000, MD_LEFT,  SLW, FST, 1'b0, "gap2");
        send(3'b010, MD_FWD,   CRU, CRU, 1'b0, "gap2_back");

        // two laps of four nodes, plan 0101
        exp_node = 0;
        exp_lap  = 0;
        do_node(1, "n1");
        for (int i = 0; i < CONFIRM; i++) begin
            send(3'b111, MD_FWD, CRU, CRU, 1'b0, "holdoff");
        end
        chk("holdoff_node", 32'(node_count), 1);
        do_node(0, "n2");
        do_node(1, "n3");
        do_node(0, "n4");
        do_node(1, "n5");
        do_node(0, "n6");
        do_node(1, "n7");
        do_node(2, "n8");
        chk("done_lap",  32'(lap_count),  2);
        chk("done_node", 32'(node_count), 0);
        send(3'b010, MD_BRAKE, 0, 0, 1'b0, "done_sticky");
        pulse_start();
        idle(2);
        chk("done_finish", 32'(finish), 1);
        chk("done_dir",    32'(motor_dir), 32'(MD_BRAKE));

        // second run: leave the search flag on left, reset mid-turn
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_finish", 32'(finish), 0);
        pulse_start();
        send(3'b010, MD_FWD,   CRU, CRU, 1'b0, "r2_c");
        send(3'b000, MD_RIGHT, FST, SLW, 1'b0, "r2_gap");
        send(3'b010, MD_FWD,   CRU, CRU, 1'b0, "r2_back");
        for (int i = 0; i < CONFIRM - 1; i++) begin
            send(3'b111, MD_FWD, CRU, CRU, 1'b0, "r2_cnf");
        end
        send(3'b111, MD_RIGHT, FULL, FULL, 1'b1, "r2_hit");
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_dir",    32'(motor_dir),  0);
        chk("mid_rst_dl",     32'(duty_l),     0);
        chk("mid_rst_dr",     32'(duty_r),     0);
        chk("mid_rst_node",   32'(node_count), 0);
        chk("mid_rst_lap",    32'(lap_count),  0);
        chk("mid_rst_pulse",  32'(node_pulse), 0);
        chk("mid_rst_finish", 32'(finish),     0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // third run: search flag back to right, counting restarts at node 0
        pulse_start();
        send(3'b010, MD_FWD,   CRU, CRU, 1'b0, "r3_c");
        send(3'b000, MD_RIGHT, FST, SLW, 1'b0, "r3_gap");
        send(3'b010, MD_FWD,   CRU, CRU, 1'b0, "r3_back");
        exp_node = 0;
        exp_lap  = 0;
        do_node(1, "r3n1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
